// File: rtl/regfile_dumper.sv
// regfile_dumper
//   Walks the register file's spare combinational read port from FIRST_REG
//   to LAST_REG and streams each word, tagged with its index, over a
//   valid/ready interface. It never writes the register file.
//
//   Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra
//   beat carrying the XOR of every dumped word. That beat has out_csum=1,
//   out_index=0 and out_last=1. When the macro is undefined, out_last marks
//   the LAST_REG beat and out_csum is tied to 0.
//
// Ports
//   clock      in   system clock, posedge
//   reset      in   synchronous, active-low
//   start      in   begin a dump (sampled only when idle)
//   busy       out  high whenever a dump is in progress
//   done       out  one-cycle pulse when the dump completes
//   rd_addr    out  register file read address
//   rd_data    in   register file read data (same-cycle, combinational)
//   out_valid  out  beat valid
//   out_ready  in   consumer accepts the beat
//   out_data   out  register word or checksum
//   out_index  out  register index (0 on the checksum beat)
//   out_last   out  final beat of the stream
//   out_csum   out  beat carries the checksum
module regfile_dumper #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        out_csum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [4:0] C_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] C_LAST  = 5'(LAST_REG);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic [31:0] r_data;
  logic [4:0]  r_index;
  logic        r_last;
  logic        w_at_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] r_acc;
  logic        r_csum;
`endif

  assign w_at_last = (r_idx == C_LAST);

  // r_idx is parked at FIRST_REG whenever the block is idle, so it can drive
  // rd_addr directly and remains stable through SEND.
  assign rd_addr   = r_idx;
  assign out_data  = r_data;
  assign out_index = r_index;
  assign out_last  = r_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign out_csum  = r_csum;
`else
  assign out_csum  = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!w_at_last) begin
            w_next = S_FETCH;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end
        end
      end
      S_CSUM: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= C_FIRST;
      r_data  <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      r_acc   <= '0;
      r_csum  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= C_FIRST;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_acc <= '0;
`endif
          end
        end
        S_FETCH: begin
          r_data  <= rd_data;
          r_index <= r_idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          r_acc   <= r_acc ^ rd_data;
          r_last  <= 1'b0;
          r_csum  <= 1'b0;
`else
          r_last  <= w_at_last;
`endif
        end
        S_SEND: begin
          if (out_ready) begin
            if (!w_at_last) begin
              r_idx <= r_idx + 5'd1;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Checksum beat is loaded into the same output registers so
              // the stream fields stay registered on every beat.
              r_data  <= r_acc;
              r_index <= '0;
              r_last  <= 1'b1;
              r_csum  <= 1'b1;
`endif
            end
          end
        end
        S_DONE: r_idx <= C_FIRST;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper
//   Self-checking bench for regfile_dumper. Two instances share one
//   behavioural register file: a full-range instance (0..31) and a
//   partial-range instance (28..31). Expected beats and completion times are
//   derived from the register contents and the observed backpressure.
//   Honours REGFILE_DUMP_CHECKSUM_EN the same way the design does.
module tb_regfile_dumper;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] regs [32];

  logic        tb_start, tb_ready, sel;

  logic        start_a, busy_a, done_a, out_valid_a, out_ready_a, out_last_a, out_csum_a;
  logic [4:0]  rd_addr_a, out_index_a;
  logic [31:0] rd_data_a, out_data_a;
  logic        start_b, busy_b, done_b, out_valid_b, out_ready_b, out_last_b, out_csum_b;
  logic [4:0]  rd_addr_b, out_index_b;
  logic [31:0] rd_data_b, out_data_b;

  assign rd_data_a   = regs[rd_addr_a];
  assign rd_data_b   = regs[rd_addr_b];
  assign start_a     = tb_start & ~sel;
  assign start_b     = tb_start & sel;
  assign out_ready_a = tb_ready & ~sel;
  assign out_ready_b = tb_ready & sel;

  regfile_dumper u_full (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_index(out_index_a),
    .out_last(out_last_a), .out_csum(out_csum_a)
  );

  regfile_dumper #(.FIRST_REG(28), .LAST_REG(31)) u_part (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_index(out_index_b),
    .out_last(out_last_b), .out_csum(out_csum_b)
  );

  // Selected-instance view
  logic        m_busy, m_done, m_valid, m_last, m_csum;
  logic [4:0]  m_rd_addr, m_index;
  logic [31:0] m_data;
  assign m_busy    = sel ? busy_b      : busy_a;
  assign m_done    = sel ? done_b      : done_a;
  assign m_valid   = sel ? out_valid_b : out_valid_a;
  assign m_last    = sel ? out_last_b  : out_last_a;
  assign m_csum    = sel ? out_csum_b  : out_csum_a;
  assign m_rd_addr = sel ? rd_addr_b   : rd_addr_a;
  assign m_index   = sel ? out_index_b : out_index_a;
  assign m_data    = sel ? out_data_b  : out_data_a;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
    logic        c;
  } beat_t;

  // One complete dump on the selected instance. ready_pct sets the random
  // acceptance rate; beat number stall_beat is additionally refused for
  // stall_len cycles; junk_start keeps start asserted while busy.
  task automatic run_dump(input logic use_b, input int unsigned ready_pct,
                          input bit junk_start, input int unsigned stall_beat,
                          input int unsigned stall_len);
    int unsigned first, last, n, stalls, stall_left, beats, ndone, exp_done;
    logic [31:0] acc, held_d;
    logic [4:0]  held_i;
    bit          stalled, rdy;
    beat_t       exp_q[$];
    beat_t       e;
    sel        = use_b;
    first      = use_b ? 28 : 0;
    last       = 31;
    n          = last - first + 1;
    acc        = '0;
    for (int unsigned k = first; k <= last; k++) begin
      e.d = regs[k]; e.i = 5'(k); e.l = (k == last) && (CS == 0); e.c = 1'b0;
      exp_q.push_back(e);
      acc ^= regs[k];
    end
    if (CS != 0) begin
      e.d = acc; e.i = '0; e.l = 1'b1; e.c = 1'b1;
      exp_q.push_back(e);
    end
    stalls = 0; stall_left = stall_len; beats = 0; ndone = 0; stalled = 0;
    held_d = '0; held_i = '0;
    @(negedge clock);
    tb_start = 1'b1;
    tb_ready = 1'b0;
    @(posedge clock);
    #1;
    if (!junk_start) tb_start = 1'b0;
    for (int unsigned c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, held_d);
        check("hold_index", 32'(m_index), 32'(held_i));
        stalled = 0;
      end
      if (m_done) begin
        exp_done = 2 * n + CS + stalls;
        check("done_cycle", c, exp_done);
        ndone++;
        tb_start = 1'b0;
        tb_ready = 1'b0;
        break;
      end
      check("busy_in_dump", 32'(m_busy), 32'd1);
      if (m_valid) begin
        if (beats == stall_beat && stall_left > 0) begin
          rdy = 0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
        end
        tb_ready = rdy;
        if (exp_q.size() > 0 && !exp_q[0].c)
          check("rd_addr_send", 32'(m_rd_addr), 32'(exp_q[0].i));
        if (rdy) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'(beats), 32'(n + CS));
          end else begin
            e = exp_q.pop_front();
            check("data", m_data, e.d);
            check("index", 32'(m_index), 32'(e.i));
            check("last", 32'(m_last), 32'(e.l));
            check("csum", 32'(m_csum), 32'(e.c));
          end
          beats++;
        end else begin
          stalls++;
          stalled = 1;
          held_d  = m_data;
          held_i  = m_index;
        end
      end else begin
        tb_ready = 1'($urandom_range(1));
      end
    end
    @(negedge clock);
    check("busy_after", 32'(m_busy), 32'd0);
    check("rd_addr_idle", 32'(m_rd_addr), first);
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clock);
      if (m_done) ndone++;
    end
    check("done_count", ndone, 32'd1);
    check("beats_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    tb_start = 1'b0;
    tb_ready = 1'b0;
    sel      = 1'b0;
    regs[0]  = 32'h0;
    for (int unsigned k = 1; k < 32; k++) regs[k] = 32'hA5A5_0000 | k;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(out_valid_a), 32'd0);
    check("rst_data", out_data_a, 32'd0);
    check("rst_index", 32'(out_index_a), 32'd0);
    check("rst_last", 32'(out_last_a), 32'd0);
    check("rst_csum", 32'(out_csum_a), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_a), 32'd0);
    check("rst_rd_addr_part", 32'(rd_addr_b), 32'd28);
    check("rst_busy_part", 32'(busy_b), 32'd0);
    reset = 1'b1;

    run_dump(1'b0, 100, 1'b0, 99, 0);  // full dump, no backpressure
    run_dump(1'b0, 100, 1'b0, 5, 3);   // 3-cycle stall on beat 5
    run_dump(1'b1, 100, 1'b0, 99, 0);  // partial range 28..31
    run_dump(1'b0, 100, 1'b1, 99, 0);  // start held high while busy

    // Reset while index 10 is pending in SEND
    sel = 1'b0;
    @(negedge clock);
    tb_start = 1'b1;
    tb_ready = 1'b1;
    @(posedge clock);
    #1 tb_start = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int unsigned c = 0; c < 200; c++) begin
        @(negedge clock);
        if (out_valid_a && out_index_a == 5'd10) begin
          hit = 1;
          break;
        end
      end
      check("mid_reach_idx10", 32'(hit), 32'd1);
    end
    tb_ready = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    check("mid_valid", 32'(out_valid_a), 32'd0);
    check("mid_busy", 32'(busy_a), 32'd0);
    check("mid_rd_addr", 32'(rd_addr_a), 32'd0);
    check("mid_data", out_data_a, 32'd0);
    check("mid_done", 32'(done_a), 32'd0);
    reset = 1'b1;
    run_dump(1'b0, 100, 1'b0, 99, 0);

    // Randomized register contents, instance choice and backpressure
    for (int unsigned t = 0; t < 6; t++) begin
      for (int unsigned k = 0; k < 32; k++) regs[k] = $urandom;
      run_dump(1'($urandom_range(1)), $urandom_range(100, 30),
               1'($urandom_range(1)), $urandom_range(6), $urandom_range(4));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug/trace engine that walks the register file's read port and streams every architectural register out over a valid/ready interface. It drives a read address into the register file's combinational read port, captures the returned word, and presents it with its index to a downstream consumer (trace FIFO, UART framer, testbench monitor). It sits beside the datapath on the spare read port and never writes the register file.

## Interface

**Parameters**
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).

**Ports**
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  begin a dump. Sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dump completes.
- rd_addr  out  5  register file read address.
- rd_data  in  32  register file read data, combinational from rd_addr in the same cycle.
- out_valid  out  1  out_data, out_index, out_last and out_csum are valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  32  register word, or checksum.
- out_index  out  5  register index of the beat; 0 on the checksum beat.
- out_last  out  1  final beat of the stream.
- out_csum  out  1  beat carries the checksum. Tied 0 when the checksum is compiled out.

## Operation

- FSM states: IDLE, FETCH, SEND, CSUM, DONE.
- IDLE:
  - rd_addr = FIRST_REG.
  - On start=1: idx <= FIRST_REG, acc <= 0, go to FETCH.
- FETCH:
  - rd_addr = idx.
  - At the edge: out_data <= rd_data, out_index <= idx, acc <= acc ^ rd_data.
  - out_last <= (idx==LAST_REG) when the checksum is compiled out, else 0.
  - Go to SEND.
- SEND:
  - out_valid=1. Data fields are held stable until out_valid && out_ready.
  - On handshake with idx!=LAST_REG: idx <= idx+1, go to FETCH.
  - On handshake with idx==LAST_REG: go to CSUM if the checksum is compiled in, else DONE.
- CSUM:
  - out_valid=1, out_data=acc, out_index=0, out_last=1, out_csum=1.
  - On handshake, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Ports:
  - rd_addr is registered and stays stable through SEND.
  - start while busy is ignored.
  - out_ready outside SEND/CSUM is ignored.
- Coherency: each word is sampled in its own FETCH cycle. A register-file write landing in the same cycle as a FETCH of that register is governed by the register file's read-during-write behaviour, not by this block. No snapshot is guaranteed across the dump.
- idx is 5 bits and never wraps; LAST_REG=31 terminates without overflow.
- Reset (reset=0 at a posedge, in any state, including mid-dump):
  - state=IDLE, idx=FIRST_REG, acc=0.
  - busy=0, done=0, out_valid=0, out_data=0, out_index=0, out_last=0, out_csum=0, rd_addr=FIRST_REG.
  - A beat pending in SEND is dropped, not completed.

## Timing

- start sampled at edge E0.
- FETCH occupies the cycle after E0; word capture is at E1.
- out_valid rises after E1.
- Minimum 2 cycles per word, with out_ready constant 1:
  - word k (k = 0 .. N-1, N = LAST_REG-FIRST_REG+1) is valid after E(2k+1) and accepted at E(2k+2).
  - Without checksum: done is high in the cycle after E(2N).
  - With checksum: checksum valid after E(2N), accepted at E(2N+1), done after E(2N+1).
  - Defaults, no checksum: 64 cycles to last handshake, done after E64, busy low after E65.
- Backpressure: each cycle of out_ready=0 in SEND/CSUM extends the dump by exactly one cycle.
- A new start can be accepted at the edge following the cycle in which done is high.

## Configuration

- REGFILE_DUMP_CHECKSUM_EN defined:
  - After the LAST_REG beat, one extra CSUM beat carries the XOR of all dumped words.
  - out_last is asserted only on that beat.
- Not defined:
  - CSUM is unreachable; out_csum is constant 0.
  - out_last is asserted on the LAST_REG beat.
  - The acc register may be optimised away.

## Test plan

- **Full dump, no backpressure, macro off.** Preload reg0=0, regk=0xA5A50000|k; start at E0, out_ready=1.
  - 32 beats with out_index 0..31 and data matching the preload.
  - out_last only on index 31; done after E64.
- **Same preload, macro on.**
  - 33rd beat: out_data=0xA5A50000, out_csum=1, out_last=1, out_index=0.
  - done after E65.
- **Backpressure.** out_ready=0 for 3 cycles on beat 5.
  - out_data/out_index stay 0x..05/5 throughout the stall.
  - done is delayed by exactly 3 cycles.
- **Reset mid-dump.** reset=0 during SEND of index 10.
  - Next cycle: out_valid=0, busy=0, rd_addr=0.
  - A new start dumps from index 0 again.
- **Ignored start.** start=1 while busy.
  - Stream unchanged; exactly one done pulse.
- **Partial range.** FIRST_REG=28, LAST_REG=31, out_ready=1.
  - 4 beats, indices 28..31; done after E8 (macro off).
